regfile_wb_ctrl: RTL

REGFILE_WB_CTRL -- requirements
Module: regfile_wb_ctrl

---
 rtl/regfile_wb_ctrl_pkg.sv | 19 +
 rtl/regfile_wb_ctrl_scoreboard.sv | 36 +++
 rtl/regfile_wb_ctrl.sv | 88 ++++++++
 3 files changed

// File: rtl/regfile_wb_ctrl_pkg.sv
// Shared CPU definitions for the writeback path: register/data widths,
// the zero register, and the write-request record.
package regfile_wb_ctrl_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 1 << REG_ADDR_W;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] reg_mask(input logic [REG_ADDR_W-1:0] r);
    reg_mask = NUM_REGS'(1) << r;
  endfunction

endpackage

// File: rtl/regfile_wb_ctrl_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at
// commit, set wins on collision; register 0 never reads as pending.
module wb_scoreboard
  import regfile_wb_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  set_en,
  input  logic [REG_ADDR_W-1:0] set_reg,
  input  logic                  clr_en,
  input  logic [REG_ADDR_W-1:0] clr_reg,
  input  logic [REG_ADDR_W-1:0] check_reg1,
  input  logic [REG_ADDR_W-1:0] check_reg2,
  output logic                  busy
);

  logic [NUM_REGS-1:0] pending;
  logic [NUM_REGS-1:0] pending_next;
  logic [NUM_REGS-1:0] set_mask;
  logic [NUM_REGS-1:0] clr_mask;

  always_comb begin
    set_mask     = set_en ? reg_mask(set_reg) : '0;
    clr_mask     = clr_en ? reg_mask(clr_reg) : '0;
    pending_next = (pending & ~clr_mask) | set_mask;
    pending_next[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= pending_next;
  end

  assign busy = pending[check_reg1] | pending[check_reg2];

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Writeback controller: arbitrates ALU and load results onto the single
// register-file write port, with anti-starvation for the ALU.
module regfile_wb_ctrl
  import regfile_wb_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_reg,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0]     mem_data,
  input  logic [REG_ADDR_W-1:0] check_reg1,
  input  logic [REG_ADDR_W-1:0] check_reg2,
  output logic                  check_busy,
  output logic                  regWrite,
  output logic [REG_ADDR_W-1:0] writeRegister,
  output logic [DATA_W-1:0]     writeData,
  output logic [15:0]           wb_count
);

  localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

  // Handshake: a source transfers on a rising edge where its valid and ready
  // are both high; the ready rules below never let both sources transfer.
  logic [SC_W-1:0] starve_cnt;
  logic            alu_starved;
  logic            mem_acc;
  logic            alu_acc;
  logic            acc_any;
  wb_req_t         acc_req;

  assign alu_starved = (starve_cnt == STARVE_MAX);

  always_comb begin
    mem_ready = !reset && !(alu_starved && alu_valid);
    alu_ready = !reset && (!mem_valid || alu_starved);
    mem_acc   = mem_valid && mem_ready;
    alu_acc   = alu_valid && alu_ready && !mem_acc;
    acc_any   = mem_acc || alu_acc;
    acc_req   = mem_acc ? wb_req_t'{rd: mem_reg, data: mem_data}
                        : wb_req_t'{rd: alu_reg, data: alu_data};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      regWrite      <= 1'b0;
      writeRegister <= '0;
      writeData     <= '0;
      wb_count      <= '0;
      starve_cnt    <= '0;
    end else begin
      // Writes to register 0 are consumed but never reach the register file.
      regWrite <= acc_any && (acc_req.rd != REG_ZERO);
      if (acc_any && (acc_req.rd != REG_ZERO)) begin
        writeRegister <= acc_req.rd;
        writeData     <= acc_req.data;
      end
      if (regWrite) wb_count <= wb_count + 16'd1;
      if (alu_valid && !alu_acc) begin
        if (!alu_starved) starve_cnt <= starve_cnt + SC_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  wb_scoreboard u_scoreboard (
    .clock      (clock),
    .reset      (reset),
    .set_en     (issue_valid && (issue_reg != REG_ZERO)),
    .set_reg    (issue_reg),
    .clr_en     (regWrite),
    .clr_reg    (writeRegister),
    .check_reg1 (check_reg1),
    .check_reg2 (check_reg2),
    .busy       (check_busy)
  );

endmodule
